// File: rtl/lfsr_auth_seq_pkg.sv
// Shared types and helpers for the LFSR challenge/response sequencer.
// Holds the FSM encoding, the reseed command nibble and a parity reduction.
package lfsr_auth_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  localparam logic [3:0] CMD_SEED = 4'hF;

  // Callers zero-extend narrower vectors, which leaves the parity unchanged.
  function automatic logic parity(input logic [31:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/lfsr_auth_seq_if.sv
// Bus-side signals of the sequencer: decoded select, read qualifier,
// challenge nibble and the tristated response bit.
interface lfsr_auth_seq_if;

  logic       sel;
  logic       rd;
  logic [3:0] addr;
  logic       sd;
  logic       sd_oe;

  modport master (
    output sel,
    output rd,
    output addr,
    input  sd,
    input  sd_oe
  );

  modport slave (
    input  sel,
    input  rd,
    input  addr,
    output sd,
    output sd_oe
  );

endinterface

// File: rtl/lfsr_auth_seq_step.sv
// Purely combinational single-step LFSR advance, Fibonacci or Galois form.
// The lock-up guard for the all-zero state lives in the caller.
module lfsr_step
  import lfsr_auth_pkg::*;
#(
  parameter int unsigned          WIDTH    = 6,
  parameter logic [WIDTH-1:0]     TAP_MASK = 6'b100001,
  parameter bit                   GALOIS   = 1'b0
) (
  input  logic [WIDTH-1:0] i_state,
  output logic [WIDTH-1:0] o_next
);

  generate
    if (GALOIS) begin : g_galois
      // Right shift; the bit falling off the bottom folds the taps back in.
      always_comb begin
        o_next = (i_state >> 1) ^ (i_state[0] ? TAP_MASK : {WIDTH{1'b0}});
      end
    end else begin : g_fibonacci
      // Left shift; the tapped parity enters at bit 0.
      always_comb begin
        o_next = {i_state[WIDTH-2:0], parity(32'(i_state & TAP_MASK))};
      end
    end
  endgenerate

endmodule

// File: rtl/lfsr_auth_seq.sv
// LFSR challenge/response authenticator: every read access returns one
// response bit, checks the challenge nibble and advances the sequence.
module lfsr_auth_seq
  import lfsr_auth_pkg::*;
#(
  parameter int unsigned      WIDTH    = 6,
  parameter logic [WIDTH-1:0] TAP_MASK = 6'b100001,
  parameter logic [WIDTH-1:0] OUT_MASK = 6'b101001,
  parameter logic [WIDTH-1:0] SEED     = 6'b000001,
  parameter logic [3:0]       KEY      = 4'hA,
  parameter int unsigned      MAX_ERR  = 3,
  parameter bit               GALOIS   = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  lfsr_auth_seq_if.slave     bus,
  output logic [WIDTH-1:0]   state_o,
  output logic [3:0]         err_cnt,
  output logic               locked
);

  state_t           r_fsm;
  state_t           w_fsm_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_lfsr_nxt;
  logic [WIDTH-1:0] w_step;
  logic [3:0]       r_err;
  logic [3:0]       w_err_nxt;
  logic [3:0]       w_err_inc;
  logic             w_acc;
  logic             w_cmd_seed;
  logic             w_chal_ok;
  logic             w_lfsr_zero;

  lfsr_step #(
    .WIDTH    (WIDTH),
    .TAP_MASK (TAP_MASK),
    .GALOIS   (GALOIS)
  ) u_step (
    .i_state (r_lfsr),
    .o_next  (w_step)
  );

  assign w_acc       = bus.sel & bus.rd;
  assign w_cmd_seed  = (bus.addr == CMD_SEED);
  assign w_chal_ok   = (bus.addr == (r_lfsr[3:0] ^ KEY));
  assign w_lfsr_zero = (r_lfsr == {WIDTH{1'b0}});
  assign w_err_inc   = r_err + 4'd1;

  // Response reflects the state before the edge; outside RUN it is forced low.
  assign bus.sd_oe = w_acc;
  assign bus.sd    = (r_fsm == ST_RUN) & parity(32'(r_lfsr & OUT_MASK));

  assign state_o = r_lfsr;
  assign err_cnt = r_err;
  assign locked  = (r_fsm == ST_LOCKED);

  always_comb begin
    w_fsm_nxt  = r_fsm;
    w_lfsr_nxt = r_lfsr;
    w_err_nxt  = r_err;
    case (r_fsm)
      ST_IDLE: begin
        if (w_acc) begin
          w_fsm_nxt  = ST_RUN;
          w_lfsr_nxt = SEED;
          w_err_nxt  = 4'd0;
        end
      end
      ST_RUN: begin
        if (w_acc) begin
          if (w_cmd_seed) begin
            w_lfsr_nxt = SEED;
            w_err_nxt  = 4'd0;
          end else begin
            w_lfsr_nxt = w_lfsr_zero ? SEED : w_step;
            // The count never exceeds MAX_ERR since reaching it leaves RUN.
            if (!w_chal_ok) begin
              w_err_nxt = w_err_inc;
              if (w_err_inc == 4'(MAX_ERR)) begin
                w_fsm_nxt = ST_LOCKED;
              end
            end
          end
        end
      end
      ST_LOCKED: begin
        if (w_acc && w_cmd_seed) begin
          w_fsm_nxt  = ST_RUN;
          w_lfsr_nxt = SEED;
          w_err_nxt  = 4'd0;
        end
      end
      default: begin
        w_fsm_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm  <= ST_IDLE;
      r_lfsr <= SEED;
      r_err  <= 4'd0;
    end else begin
      r_fsm  <= w_fsm_nxt;
      r_lfsr <= w_lfsr_nxt;
      r_err  <= w_err_nxt;
    end
  end

endmodule

// File: doc/lfsr_auth_seq.md
LFSR_AUTH_SEQ -- requirements
Module: lfsr_auth_seq

Interface
REQ-001 Parameter WIDTH, default 6: LFSR state width, legal range 4..32.
REQ-002 Parameter TAP_MASK, default 6'b100001: feedback taps, WIDTH bits.
REQ-003 Parameter OUT_MASK, default 6'b101001: response-bit taps, WIDTH bits.
REQ-004 Parameter SEED, default 6'b000001: reload value, WIDTH bits, nonzero.
REQ-005 Parameter KEY, default 4'hA: challenge key nibble.
REQ-006 Parameter MAX_ERR, default 3: challenge mismatches before lock, legal range 1..15.
REQ-007 Parameter GALOIS, default 0: 0 selects Fibonacci, 1 selects Galois stepping.
REQ-008 One clock; reset is synchronous and active-high; ports clk and rst.
REQ-009 clk  input  1  rising-edge clock.
REQ-010 rst  input  1  synchronous active-high reset.
REQ-011 sel  input  1  decoded device select, already qualified by the upper address bits.
REQ-012 rd  input  1  bus read qualifier; high means read.
REQ-013 addr  input  4  challenge or command nibble, bus address bits 7..4.
REQ-014 sd  output  1  response data bit.
REQ-015 sd_oe  output  1  response drive enable, for the pad tristate.
REQ-016 state_o  output  WIDTH  current LFSR state.
REQ-017 err_cnt  output  4  challenge mismatch count.
REQ-018 locked  output  1  high while the FSM is in LOCKED.

Function
REQ-019 Access acc = sel & rd, sampled on every rising clk edge; each cycle with acc high counts as one access.
REQ-020 sd_oe SHALL equal acc, combinationally.
REQ-021 sd SHALL equal parity(state & OUT_MASK) of the pre-edge state while in RUN, and 0 while in LOCKED or IDLE.
REQ-022 Fibonacci step: next = {state[WIDTH-2:0], parity(state & TAP_MASK)}.
REQ-023 Galois step: next = (state >> 1) ^ (state[0] ? TAP_MASK : 0).
REQ-024 The FSM SHALL have three states: IDLE, RUN and LOCKED.
REQ-025 IDLE, on any access: load state <= SEED, clear err_cnt and go to RUN.
REQ-026 RUN, access with addr == 4'hF (CMD_SEED): load state <= SEED and clear err_cnt; this takes priority over all other access handling.
REQ-027 RUN, any other access: advance state by one step.
REQ-028 Challenge check on the same access as REQ-027: addr != (state[3:0] ^ KEY) SHALL increment err_cnt; a match leaves err_cnt unchanged.
REQ-029 When err_cnt reaches MAX_ERR, the FSM SHALL enter LOCKED on the same edge; err_cnt saturates at MAX_ERR.
REQ-030 LOCKED: state is frozen and only a CMD_SEED access returns the FSM to RUN, with state reloaded and err_cnt cleared.
REQ-031 An all-zero state SHALL reload SEED in place of stepping (lock-up guard).
REQ-032 No access in a cycle: all registers hold.
REQ-033 There is no added latency: a response reflects the state before the edge, and the advance is visible on state_o one cycle later.

Reset
REQ-034 While rst is high at a clk edge: FSM to IDLE, state to SEED, err_cnt to 0, locked to 0.
REQ-035 rst overrides a simultaneous access; an access in progress is discarded.

Structure
REQ-036 Package lfsr_auth_pkg SHALL hold the FSM state enum, CMD_SEED = 4'hF, and a parity function.
REQ-037 Sub-module lfsr_step SHALL be purely combinational, parameterised by WIDTH, TAP_MASK and GALOIS, computing the next state.
REQ-038 The registered FSM, challenge check and err_cnt SHALL live in lfsr_auth_seq.

Verification
REQ-039 Reset, then an access with addr=4'hF -> RUN, state_o=6'b000001, err_cnt=0.
REQ-040 From SEED, two accesses with matching challenges (4'hB, then 4'h9) -> sd=1 on each, state_o 000011 then 000111, err_cnt=0.
REQ-041 Three accesses with mismatched addr -> err_cnt 1,2,3, locked=1 after the third, and sd=0 on later accesses while state_o is frozen.
REQ-042 While LOCKED, an access with addr=4'hF -> locked=0, err_cnt=0, state_o=SEED.
REQ-043 rst asserted in the same cycle as an access -> IDLE, state_o=SEED, and no step occurs.
REQ-044 GALOIS=1, WIDTH=8, TAP_MASK=8'hB8 -> state sequence matches the reference model for 255 steps before repeating, with no all-zero state.
